// File: rtl/pwm_pkg.sv
// Shared definitions for the 3-bit PWM generator and its receive-side duty decoder.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH = 3;

    function automatic int unsigned pwm_period(input int unsigned width);
        return 32'd1 << width;
    endfunction

    typedef enum logic [1:0] {
        ACQ,
        HIGH,
        LOW,
        STK
    } dec_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus history flop producing enable-qualified rise/fall strobes.
module pwm_sync_edge (
    input  logic Clock,
    input  logic CLR_N,
    input  logic en,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_ff @(posedge Clock or negedge CLR_N) begin
        if (!CLR_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // History only advances on enabled cycles, so an edge arriving while
    // disabled is presented on the next enabled cycle instead of being lost.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        hist_d = en ? sync_q : hist_q;
        sync   = sync_q;
        rise   = en & sync_q & ~hist_q;
        fall   = en & ~sync_q & hist_q;
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers PWM duty (high-time per period) and flags period errors and stuck levels.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             Clock,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             PWM_IN,
    output logic [WIDTH:0]   DUTY,
    output logic             DUTY_VALID,
    output logic             PERIOD_ERR,
    output logic             STUCK
);
    localparam int unsigned PERIOD = pwm_period(WIDTH);
    localparam int unsigned CW     = WIDTH + 2;
    localparam logic [CW-1:0] SAT_C    = CW'(2 * PERIOD);
    localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [WIDTH:0] DUTY_MAX = (WIDTH + 1)'(PERIOD);

    dec_state_e state_q, state_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] hi_q, hi_d;
    logic [WIDTH:0] duty_q, duty_d;
    logic valid_q, valid_d;
    logic perr_q, perr_d;

    logic sync, rise, fall;
    logic [CW-1:0] per_inc, hi_inc;

    pwm_sync_edge u_sync_edge (
        .Clock    (Clock),
        .CLR_N    (CLR_N),
        .en       (CE),
        .async_in (PWM_IN),
        .sync     (sync),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge Clock or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ACQ;
            per_q   <= '0;
            hi_q    <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            hi_q    <= hi_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        per_inc = (per_q == SAT_C) ? per_q : per_q + ONE_C;
        hi_inc  = (sync && hi_q != SAT_C) ? hi_q + ONE_C : hi_q;
        state_d = state_q;
        per_d   = per_q;
        hi_d    = hi_q;
        if (CE) begin
            unique case (state_q)
                ACQ: begin
                    per_d = '0;
                    hi_d  = '0;
                    if (rise) begin
                        state_d = HIGH;
                        per_d   = ONE_C;
                        hi_d    = ONE_C;
                    end
                end
                HIGH: begin
                    per_d = per_inc;
                    hi_d  = hi_inc;
                    if (fall)
                        state_d = LOW;
                    else if (per_inc == SAT_C)
                        state_d = STK;
                end
                LOW: begin
                    // A closing rise takes priority over saturation.
                    if (rise) begin
                        state_d = HIGH;
                        per_d   = ONE_C;
                        hi_d    = ONE_C;
                    end else begin
                        per_d = per_inc;
                        hi_d  = hi_inc;
                        if (per_inc == SAT_C)
                            state_d = STK;
                    end
                end
                STK: begin
                    per_d = '0;
                    hi_d  = '0;
                    if (rise) begin
                        state_d = HIGH;
                        per_d   = ONE_C;
                        hi_d    = ONE_C;
                    end else if (fall) begin
                        state_d = ACQ;
                    end
                end
                default: state_d = ACQ;
            endcase
        end
    end

    always_comb begin
        duty_d  = duty_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        if (CE && state_q == LOW && rise) begin
            duty_d  = (hi_q > PERIOD_C) ? DUTY_MAX : hi_q[WIDTH:0];
            valid_d = 1'b1;
            perr_d  = (per_q != PERIOD_C);
        end else if (state_q != STK && state_d == STK) begin
            duty_d  = sync ? DUTY_MAX : '0;
            valid_d = 1'b1;
        end
        DUTY       = duty_q;
        DUTY_VALID = valid_q;
        PERIOD_ERR = perr_q;
        STUCK      = (state_q == STK);
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench: directed and random PWM waveforms against a timestamp-based decode model.
module tb_pwm_duty_decoder;

    localparam int W = 3;
    localparam int P = 8;
    localparam int M_ACQ   = 0;
    localparam int M_MEAS  = 1;
    localparam int M_STUCK = 2;

    logic Clock = 1'b0;
    logic CLR_N = 1'b1;
    logic CE = 1'b0;
    logic PWM_IN = 1'b0;
    logic [W:0] DUTY;
    logic DUTY_VALID, PERIOD_ERR, STUCK;

    int checks = 0;
    int failures = 0;

    // Reference model: input reaches the decoder two clocks late; a period is
    // measured from rise timestamp to rise timestamp in enabled cycles.
    bit dl0, dl1, lvl_prev, have_fall;
    int mode, ena_cnt, start_idx, fall_idx;
    int exp_duty;
    bit exp_valid, exp_perr;

    always #5 Clock = ~Clock;

    pwm_duty_decoder #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .CLR_N      (CLR_N),
        .CE         (CE),
        .PWM_IN     (PWM_IN),
        .DUTY       (DUTY),
        .DUTY_VALID (DUTY_VALID),
        .PERIOD_ERR (PERIOD_ERR),
        .STUCK      (STUCK)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        dl0 = 0; dl1 = 0; lvl_prev = 0; have_fall = 0;
        mode = M_ACQ; ena_cnt = 0; start_idx = 0; fall_idx = 0;
        exp_duty = 0; exp_valid = 0; exp_perr = 0;
    endtask

    task automatic model_step(input bit pin, input bit ce);
        bit s, r, f;
        int n, hi;
        s = dl1;
        exp_valid = 0;
        exp_perr = 0;
        if (ce) begin
            n = ena_cnt;
            ena_cnt++;
            r = s && !lvl_prev;
            f = !s && lvl_prev;
            lvl_prev = s;
            if (mode == M_ACQ) begin
                if (r) begin mode = M_MEAS; start_idx = n; have_fall = 0; end
            end else if (mode == M_MEAS) begin
                if (r && have_fall) begin
                    hi = fall_idx - start_idx;
                    exp_duty = (hi > P) ? P : hi;
                    exp_valid = 1;
                    exp_perr = ((n - start_idx) != P);
                    start_idx = n;
                    have_fall = 0;
                end else if (f && !have_fall) begin
                    have_fall = 1;
                    fall_idx = n;
                end else if (n - start_idx + 1 >= 2 * P) begin
                    mode = M_STUCK;
                    exp_duty = s ? P : 0;
                    exp_valid = 1;
                end
            end else begin
                if (r) begin mode = M_MEAS; start_idx = n; have_fall = 0; end
                else if (f) mode = M_ACQ;
            end
        end
        dl1 = dl0;
        dl0 = pin;
    endtask

    task automatic cycle(input bit pin, input bit ce);
        PWM_IN = pin;
        CE = ce;
        @(posedge Clock);
        model_step(pin, ce);
        @(negedge Clock);
        check_eq("duty", DUTY, exp_duty);
        check_eq("duty_valid", DUTY_VALID, exp_valid);
        check_eq("period_err", PERIOD_ERR, exp_perr);
        check_eq("stuck", STUCK, (mode == M_STUCK));
    endtask

    task automatic pwm_periods(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) cycle(1, 1);
            repeat (lo) cycle(0, 1);
        end
    endtask

    task automatic pwm_gated(input int hi, input int lo, input int n);
        repeat (n) begin
            repeat (hi) begin cycle(1, 1); cycle(1, 0); end
            repeat (lo) begin cycle(0, 1); cycle(0, 0); end
        end
    endtask

    task automatic apply_reset();
        #2 CLR_N = 1'b0;
        #1;
        check_eq("reset_duty", DUTY, 0);
        check_eq("reset_valid", DUTY_VALID, 0);
        check_eq("reset_perr", PERIOD_ERR, 0);
        check_eq("reset_stuck", STUCK, 0);
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        CLR_N = 1'b1;
    endtask

    initial begin
        int dv [4] = '{3, 1, 5, 7};
        model_reset();
        #1 CLR_N = 1'b0;
        #1;
        check_eq("por_duty", DUTY, 0);
        check_eq("por_valid", DUTY_VALID, 0);
        check_eq("por_perr", PERIOD_ERR, 0);
        check_eq("por_stuck", STUCK, 0);
        @(negedge Clock);
        @(negedge Clock);
        CLR_N = 1'b1;

        // Steady decode at several duties.
        foreach (dv[i]) begin
            pwm_periods(dv[i], P - dv[i], 6);
            check_eq("steady_duty", DUTY, dv[i]);
        end

        // Period error, then back to nominal periods.
        pwm_periods(4, 6, 3);
        pwm_periods(4, 4, 4);
        check_eq("recover_duty", DUTY, 4);

        // Stuck low, stuck high, release.
        pwm_periods(3, 5, 2);
        repeat (20) cycle(0, 1);
        check_eq("stuck_low_flag", STUCK, 1);
        check_eq("stuck_low_duty", DUTY, 0);
        repeat (20) cycle(1, 1);
        check_eq("stuck_high_flag", STUCK, 1);
        check_eq("stuck_high_duty", DUTY, P);
        pwm_periods(0, 3, 1);
        pwm_periods(2, 6, 4);

        // CE gating with a stretched duty-2 waveform.
        pwm_gated(2, 6, 5);
        check_eq("gated_duty", DUTY, 2);

        // Reset in the middle of a high phase.
        pwm_periods(3, 5, 2);
        repeat (4) cycle(1, 1);
        apply_reset();
        pwm_periods(3, 5, 4);

        // Closing rise coincides with counter saturation; one past it goes stuck.
        pwm_periods(5, 10, 3);
        check_eq("boundary_no_stuck", STUCK, 0);
        pwm_periods(5, 11, 3);
        pwm_periods(6, 2, 3);

        // Random waveforms with random enable.
        for (int k = 0; k < 60; k++) begin
            int hi, lo;
            bit gated;
            hi = $urandom_range(1, 10);
            lo = $urandom_range(1, 10);
            gated = ($urandom_range(0, 2) == 0);
            repeat (hi) cycle(1, gated ? ($urandom_range(0, 3) != 0) : 1'b1);
            repeat (lo) cycle(0, gated ? ($urandom_range(0, 3) != 0) : 1'b1);
            if ($urandom_range(0, 29) == 0) apply_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
